// File: rtl/fsab_arbiter.sv
// Two-client FSAB request arbiter: per-client beat FIFOs merged onto one fsabo stream,
// write bursts kept atomic. Define FSAB_ARB_FIXED_PRIO_EN for fixed client-0-first priority.
module fsab_arbiter #(
  parameter int FIFO_DEPTH   = 8,
  parameter int FIFO_AW      = 3,
  parameter int DOWN_CREDITS = 16,
  parameter int CRED_W       = 5,
  parameter int FSAB_REQ_HI  = 0,
  parameter int FSAB_DID_HI  = 3,
  parameter int FSAB_ADDR_HI = 30,
  parameter int FSAB_LEN_HI  = 3,
  parameter int DATA_HI      = 63,
  parameter int MASK_HI      = 7
) (
  input  logic                  clk,
  input  logic                  Nrst,
  input  logic                  c0_fsabo_valid,
  input  logic [FSAB_REQ_HI:0]  c0_fsabo_mode,
  input  logic [FSAB_DID_HI:0]  c0_fsabo_did,
  input  logic [FSAB_DID_HI:0]  c0_fsabo_subdid,
  input  logic [FSAB_ADDR_HI:0] c0_fsabo_addr,
  input  logic [FSAB_LEN_HI:0]  c0_fsabo_len,
  input  logic [DATA_HI:0]      c0_fsabo_data,
  input  logic [MASK_HI:0]      c0_fsabo_mask,
  output logic                  c0_fsabo_credit,
  input  logic                  c1_fsabo_valid,
  input  logic [FSAB_REQ_HI:0]  c1_fsabo_mode,
  input  logic [FSAB_DID_HI:0]  c1_fsabo_did,
  input  logic [FSAB_DID_HI:0]  c1_fsabo_subdid,
  input  logic [FSAB_ADDR_HI:0] c1_fsabo_addr,
  input  logic [FSAB_LEN_HI:0]  c1_fsabo_len,
  input  logic [DATA_HI:0]      c1_fsabo_data,
  input  logic [MASK_HI:0]      c1_fsabo_mask,
  output logic                  c1_fsabo_credit,
  output logic                  fsabo_valid,
  output logic [FSAB_REQ_HI:0]  fsabo_mode,
  output logic [FSAB_DID_HI:0]  fsabo_did,
  output logic [FSAB_DID_HI:0]  fsabo_subdid,
  output logic [FSAB_ADDR_HI:0] fsabo_addr,
  output logic [FSAB_LEN_HI:0]  fsabo_len,
  output logic [DATA_HI:0]      fsabo_data,
  output logic [MASK_HI:0]      fsabo_mask,
  input  logic                  fsabi_credit
);

  localparam logic [FSAB_REQ_HI:0] FSAB_WRITE = 1;
  localparam logic [FSAB_LEN_HI:0] LEN_ONE    = 1;
  localparam logic [CRED_W-1:0]    CRED_MAX   = CRED_W'(DOWN_CREDITS);

  typedef struct packed {
    logic [FSAB_REQ_HI:0]  mode;
    logic [FSAB_DID_HI:0]  did;
    logic [FSAB_DID_HI:0]  subdid;
    logic [FSAB_ADDR_HI:0] addr;
    logic [FSAB_LEN_HI:0]  len;
    logic [DATA_HI:0]      data;
    logic [MASK_HI:0]      mask;
  } beat_t;

  typedef enum logic {IDLE, BURST} state_t;

  beat_t               fifo_mem [2][FIFO_DEPTH];
  logic [FIFO_AW:0]    wr_ptr [2];
  logic [FIFO_AW:0]    rd_ptr [2];
  beat_t               in_beat [2];
  beat_t               head [2];
  logic [1:0]          in_vld, empty, full, push, pop;

  state_t              state, state_n;
  logic                gnt, gnt_n, sel, issue, have_cred;
  logic [1:0]          eligible;
  logic [FSAB_LEN_HI:0] remain, remain_n;
  logic [CRED_W-1:0]   down_cred, down_cred_n;
`ifndef FSAB_ARB_FIXED_PRIO_EN
  logic                rr_last, rr_last_n;
`endif

  beat_t               out_beat_p1;
  logic                vld_p1;
  logic [1:0]          pop_p1, cred_p2;

  assign in_vld     = {c1_fsabo_valid, c0_fsabo_valid};
  assign in_beat[0] = {c0_fsabo_mode, c0_fsabo_did, c0_fsabo_subdid, c0_fsabo_addr,
                       c0_fsabo_len, c0_fsabo_data, c0_fsabo_mask};
  assign in_beat[1] = {c1_fsabo_mode, c1_fsabo_did, c1_fsabo_subdid, c1_fsabo_addr,
                       c1_fsabo_len, c1_fsabo_data, c1_fsabo_mask};

  // Extra pointer bit distinguishes full from empty when the indices match.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      empty[i] = (wr_ptr[i] == rd_ptr[i]);
      full[i]  = (wr_ptr[i][FIFO_AW] != rd_ptr[i][FIFO_AW]) &&
                 (wr_ptr[i][FIFO_AW-1:0] == rd_ptr[i][FIFO_AW-1:0]);
      head[i]  = fifo_mem[i][rd_ptr[i][FIFO_AW-1:0]];
    end
  end

  // A pop on the same edge frees a slot, so a push into a full FIFO is still accepted.
  assign push = in_vld & (~full | pop);

  always_ff @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (push[i]) fifo_mem[i][wr_ptr[i][FIFO_AW-1:0]] <= in_beat[i];
    end
  end

  always_ff @(posedge clk) begin
    if (!Nrst) begin
      for (int i = 0; i < 2; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (push[i]) wr_ptr[i] <= wr_ptr[i] + 1'b1;
        if (pop[i])  rd_ptr[i] <= rd_ptr[i] + 1'b1;
      end
    end
  end

  assign have_cred = (down_cred != '0);

  always_comb begin
    state_n  = state;
    gnt_n    = gnt;
    remain_n = remain;
    sel      = gnt;
    issue    = 1'b0;
    pop      = '0;
    eligible = ~empty & {2{have_cred}};
`ifndef FSAB_ARB_FIXED_PRIO_EN
    rr_last_n = rr_last;
`endif
    case (state)
      IDLE: begin
`ifdef FSAB_ARB_FIXED_PRIO_EN
        sel = !eligible[0];
`else
        if (&eligible) sel = ~rr_last;
        else           sel = !eligible[0];
`endif
        issue = |eligible;
        if (issue) begin
`ifndef FSAB_ARB_FIXED_PRIO_EN
          rr_last_n = sel;
`endif
          // len 0 and 1 writes are single-beat packets, like reads.
          if (head[sel].mode == FSAB_WRITE && head[sel].len > LEN_ONE) begin
            state_n  = BURST;
            gnt_n    = sel;
            remain_n = head[sel].len - LEN_ONE;
          end
        end
      end
      BURST: begin
        sel   = gnt;
        issue = !empty[gnt] && have_cred;
        if (issue) begin
          remain_n = remain - LEN_ONE;
          if (remain == LEN_ONE) state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
    if (issue) pop[sel] = 1'b1;
  end

  // Returned credits above the reset grant are ignored.
  always_comb begin
    down_cred_n = down_cred;
    if (issue && !fsabi_credit)
      down_cred_n = down_cred - 1'b1;
    else if (!issue && fsabi_credit && down_cred != CRED_MAX)
      down_cred_n = down_cred + 1'b1;
  end

  // Control stage: FSM, credits, valid and credit-return pipeline
  always_ff @(posedge clk) begin
    if (!Nrst) begin
      state     <= IDLE;
      gnt       <= 1'b0;
      remain    <= '0;
      down_cred <= CRED_MAX;
      vld_p1    <= 1'b0;
      pop_p1    <= '0;
      cred_p2   <= '0;
`ifndef FSAB_ARB_FIXED_PRIO_EN
      rr_last   <= 1'b1;
`endif
    end else begin
      state     <= state_n;
      gnt       <= gnt_n;
      remain    <= remain_n;
      down_cred <= down_cred_n;
      vld_p1    <= issue;
      pop_p1    <= pop;
      cred_p2   <= pop_p1;
`ifndef FSAB_ARB_FIXED_PRIO_EN
      rr_last   <= rr_last_n;
`endif
    end
  end

  // Output data stage: holds the last issued beat while valid is low
  always_ff @(posedge clk) begin
    if (!Nrst)      out_beat_p1 <= '0;
    else if (issue) out_beat_p1 <= head[sel];
  end

  assign fsabo_valid     = vld_p1;
  assign fsabo_mode      = out_beat_p1.mode;
  assign fsabo_did       = out_beat_p1.did;
  assign fsabo_subdid    = out_beat_p1.subdid;
  assign fsabo_addr      = out_beat_p1.addr;
  assign fsabo_len       = out_beat_p1.len;
  assign fsabo_data      = out_beat_p1.data;
  assign fsabo_mask      = out_beat_p1.mask;
  assign c0_fsabo_credit = cred_p2[0];
  assign c1_fsabo_credit = cred_p2[1];

endmodule
